// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N byte requesters,
// with optional line locking so a requester's line is never interleaved with another's.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter bit LINE_LOCK = 1'b1,
  parameter int HOLD      = 1023
) (
  input  logic                   clk,
  input  logic                   resetq,
  input  logic [N-1:0]           req,
  input  logic [8*N-1:0]         data,
  output logic [N-1:0]           ack,
  output logic                   uart_wr,
  output logic [7:0]             uart_dat,
  input  logic                   uart_busy,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   locked
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    dat_q, dat_d;
  logic          locked_q, locked_d;
  logic [CW-1:0] hold_q, hold_d;

  logic [7:0]    data_arr [N];
  logic          rr_found;
  logic [IW-1:0] rr_win;
  logic [IW-1:0] cand;
  logic          win_valid;
  logic [IW-1:0] win_id;
  logic          issue_en;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign data_arr[gi] = data[8*gi +: 8];
    assign ack[gi]      = issue_en && (grant_q == IW'(gi));
  end

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_q) + k) % N);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

  assign win_valid = locked_q ? req[grant_q] : rr_found;
  assign win_id    = locked_q ? grant_q : rr_win;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IW'(N - 1);
      dat_q    <= '0;
      locked_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      dat_q    <= dat_d;
      locked_q <= locked_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!uart_busy && win_valid) state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = DRAIN;
      DRAIN:   if (!uart_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d  = grant_q;
    last_d   = last_q;
    dat_d    = dat_q;
    locked_d = locked_q;
    hold_d   = hold_q;
    if (state_q == IDLE && !uart_busy) begin
      if (win_valid) begin
        grant_d = win_id;
        last_d  = win_id;
        dat_d   = data_arr[win_id];
        hold_d  = '0;
      end else if (locked_q) begin
        // Owner went quiet: release after HOLD idle cycles.
        if (hold_q == CW'(HOLD - 1)) begin
          locked_d = 1'b0;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
    end
    if (state_q == ISSUE) begin
      locked_d = LINE_LOCK && (dat_q != 8'h0A);
    end
  end

  always_comb begin
    issue_en = (state_q == ISSUE);
    uart_wr  = issue_en;
  end

  assign grant_id = grant_q;
  assign uart_dat = dat_q;
  assign locked   = locked_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart` transmitter between N byte-stream requesters, such as CPU console, debug monitor and trace port, so that their output never interleaves mid-line. It arbitrates round-robin and issues each won byte to the transmitter with a single-cycle write strobe. It tracks the transmitter's busy flag through the whole frame. With line locking enabled, it holds the grant on one requester until that requester's line ends (0x0A) or the requester goes quiet for HOLD cycles. It sits between the requesters and the `uart` write port (`uart_wr_i`/`uart_dat_i`/`uart_busy`).

## Interface
- N, default 4: number of requesters, 2..8.
- LINE_LOCK, default 1: 1 keeps the grant on a requester until it sends 0x0A or times out; 0 gives pure per-byte round-robin.
- HOLD, default 1023: number of idle IDLE-state cycles a locked owner may leave req low before the lock is released. Must be ≥1.

- clk  in  1  system clock; all logic on posedge.
- resetq  in  1  asynchronous, active-low reset.
- req  in  N  per-requester byte pending; held with data stable until ack.
- data  in  8N  requester i's byte on data[8i+7:8i].
- ack  out  N  one-hot, one-cycle pulse; the byte is committed to the transmitter.
- uart_wr  out  1  to `uart_wr_i`; one-cycle strobe.
- uart_dat  out  8  to `uart_dat_i`; registered.
- uart_busy  in  1  from `uart_busy`.
- grant_id  out  $clog2(N)  requester that owns the current or last byte.
- locked  out  1  a line lock is active on grant_id.

## Operation
- **Reset values:** state=IDLE, uart_wr=0, uart_dat=0, ack=0, grant_id=0, locked=0, hold counter=0. The round-robin pointer is set to last=N-1, so requester 0 has top priority first.
- **States:** IDLE, ISSUE, SETTLE, DRAIN.
- **IDLE:**
  - If uart_busy=1, stay.
  - Else, if locked and req[grant_id]=1: winner = grant_id.
  - Else, if locked and req[grant_id]=0: no winner. Increment the hold counter. When it reaches HOLD, clear locked and zero the counter; arbitration resumes the next cycle.
  - Else (unlocked): winner is the first requester with req=1 scanning last+1, last+2, … mod N.
  - When there is a winner:
    - latch grant_id=winner and uart_dat=data[winner]; update last=winner;
    - zero the hold counter;
    - go to ISSUE.
- **ISSUE** (exactly one cycle):
  - Assert uart_wr=1 and ack[grant_id]=1.
  - If LINE_LOCK=1: locked = (uart_dat != 8'h0A). Otherwise locked stays 0.
  - Go to SETTLE.
- **SETTLE** (exactly one cycle): lets `uart` register bitcount so that uart_busy rises. Go to DRAIN.
- **DRAIN:** stay while uart_busy=1; go to IDLE on uart_busy=0.
- **Commitment:** once a byte is latched in IDLE it is committed. If req drops during ISSUE, the byte is still sent and ack still pulses.
- **Data width:** data is passed unmodified; 0x0A detection uses all 8 bits.
- **Lock sequencing:** a lock released by timeout applies from the following IDLE cycle, and rotation continues from last=old owner. Other requesters see no bytes while locked, however long they wait.
- **Reset mid-frame:** everything returns to reset values at once. uart_wr drops asynchronously, so no strobe is emitted after reset deasserts until a new arbitration.

## Timing
- Cycle T: IDLE, busy=0, req[i]=1, arbitration.
- T+1: uart_wr=1, ack[i]=1.
- T+2: SETTLE; uart_busy=1 from `uart`.
- DRAIN lasts until the frame ends; busy falls after 10 ser_clk bit periods.
- The first IDLE cycle after busy falls can arbitrate again.
- Per-byte overhead beyond the UART frame is 3 cycles (IDLE, ISSUE, SETTLE).
- uart_wr is never asserted while uart_busy=1.
- ack is never asserted to more than one requester per byte.

## Test plan
- **Single requester:** req[2]=1, data=0x41, LINE_LOCK=0 -> ack[2] and uart_wr together at T+1, uart_dat=0x41, grant_id=2; next strobe only after busy falls.
- **Round-robin:** all four req held with LINE_LOCK=0 -> grant order 0,1,2,3,0, one byte each; each ack exactly once per frame.
- **Line lock:** req0 streams "AB\n" while req1 holds req -> three bytes from 0, locked=1 after A and B, locked=0 after 0x0A; next grant is 1.
- **Hold timeout:** HOLD=8; req0 sends 'A' then drops req while req1 waits -> requester 1 granted only after 8 IDLE cycles; locked falls on the 8th cycle.
- **Withdraw after latch:** req3 drops at T+1 -> ack[3] still pulses and the byte is transmitted; no second strobe.
- **Reset mid-frame:** resetq low during DRAIN -> uart_wr=0, ack=0, locked=0, grant_id=0 immediately; after release, requester 0 has priority.
